// File: rtl/blk_mm_pkg.sv
// Shared definitions for the blocked matrix-multiply datapath.
// Holds the default width constants, the partials-per-element helper, the
// accumulator FSM state encoding and the result-FIFO entry layout.
// Optional feature macro used by block_accum: BLOCK_ACCUM_SAT_EN.
package blk_mm_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 8;
  localparam int unsigned DEF_MATRIX_SIZE = 3;
  localparam int unsigned DEF_BLOCK_SIZE  = 3;
  localparam int unsigned DEF_FIFO_DEPTH  = 4;
  localparam int unsigned DEF_PART_WIDTH  = 2 * DEF_DATA_WIDTH + 2;
  localparam int unsigned DEF_ACC_WIDTH   = 2 * DEF_DATA_WIDTH + 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Number of block partials that make up one result element.
  function automatic int unsigned num_blk(input int unsigned matrix_size,
                                          input int unsigned block_size);
    return (block_size == 0) ? 0 : matrix_size / block_size;
  endfunction

  // Index width for a 0..n-1 counter, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_COORD_WIDTH = idx_width(DEF_MATRIX_SIZE);

  // Result FIFO entry at the default configuration; block_accum declares the
  // same field order at its own parameterised widths.
  typedef struct packed {
    logic [DEF_ACC_WIDTH-1:0]   data;
    logic [DEF_COORD_WIDTH-1:0] row;
    logic [DEF_COORD_WIDTH-1:0] col;
    logic                       last;
  } res_entry_t;

endpackage

// File: rtl/res_fifo.sv
// Synchronous show-ahead FIFO with a registered head.
// The head register always holds the oldest entry, so o_data/o_valid are
// flop outputs and a push into an empty FIFO is visible right after the edge.
// Ports:
//   i_clock, i_reset      clock, asynchronous active-high reset
//   i_clear               synchronous flush (overrides push/pop)
//   i_push, i_data        write request and entry (ignored when full)
//   i_pop                 consume head (ignored when empty)
//   o_data, o_valid       registered head entry and its valid
//   o_full                registered full flag
//   o_full_nxt_c          full flag the FIFO will have after this edge
//   o_empty_nxt_c         empty flag the FIFO will have after this edge
module res_fifo
  import blk_mm_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full,
  output logic             o_full_nxt_c,
  output logic             o_empty_nxt_c
);

  localparam int unsigned PTR_W = idx_width(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_head;
  logic             r_valid;
  logic             r_full;

  logic [PTR_W-1:0] w_wr_nxt;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_head_nxt;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop & r_valid;

  // Pointer and occupancy update; clear wins over any transfer.
  always_comb begin
    w_wr_nxt    = r_wr_ptr;
    w_rd_nxt    = r_rd_ptr;
    w_count_nxt = r_count;
    if (i_clear) begin
      w_wr_nxt    = '0;
      w_rd_nxt    = '0;
      w_count_nxt = '0;
    end else begin
      if (w_push) w_wr_nxt = r_wr_ptr + PTR_W'(1);
      if (w_pop)  w_rd_nxt = r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Next head: the entry at the next read pointer. If that slot is the one
  // being written this edge, take the incoming data. Holds when going empty.
  always_comb begin
    w_head_nxt = r_head;
    if (i_clear) begin
      w_head_nxt = '0;
    end else if (w_count_nxt != '0) begin
      if (w_push && (w_rd_nxt == r_wr_ptr)) w_head_nxt = i_data;
      else                                  w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  assign o_full_nxt_c  = (w_count_nxt == CNT_W'(DEPTH));
  assign o_empty_nxt_c = (w_count_nxt == '0);

  // Storage array needs no reset; occupancy tracks what is valid.
  always_ff @(posedge i_clock) begin
    if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers, occupancy and the registered head/flags.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      r_valid  <= 1'b0;
      r_full   <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      r_head   <= w_head_nxt;
      r_valid  <= ~o_empty_nxt_c;
      r_full   <= o_full_nxt_c;
    end
  end

  assign o_data  = r_head;
  assign o_valid = r_valid;
  assign o_full  = r_full;

endmodule

// File: rtl/block_accum.sv
// Block accumulator: sums the MATRIX_SIZE/BLOCK_SIZE partial dot products of
// each result element and streams finished elements, row-major, through a
// small show-ahead FIFO with row/col tags and a last-element marker.
// Macro BLOCK_ACCUM_SAT_EN: when defined, sums clamp to all-ones and o_ovf
// latches sticky; when undefined, sums wrap and o_ovf stays 0.
// Ports:
//   i_clock, i_reset          clock, asynchronous active-high reset
//   i_clear                   synchronous abort of the current matrix
//   i_part_valid/o_part_ready partial handshake, i_part_data unsigned partial
//   o_res_valid/i_res_ready   result handshake
//   o_res_data                accumulated element
//   o_res_row, o_res_col      element coordinates
//   o_res_last                head is element (N-1,N-1)
//   o_ovf                     sticky saturation flag
//   o_done                    one-cycle pulse once the matrix has drained
module block_accum
  import blk_mm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter int unsigned BLOCK_SIZE  = DEF_BLOCK_SIZE,
  parameter int unsigned PART_WIDTH  = 2 * DATA_WIDTH + 2,
  parameter int unsigned ACC_WIDTH   = 2 * DATA_WIDTH + 4,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic                                i_clear,
  input  logic                                i_part_valid,
  output logic                                o_part_ready,
  input  logic [PART_WIDTH-1:0]               i_part_data,
  output logic                                o_res_valid,
  input  logic                                i_res_ready,
  output logic [ACC_WIDTH-1:0]                o_res_data,
  output logic [idx_width(MATRIX_SIZE)-1:0]   o_res_row,
  output logic [idx_width(MATRIX_SIZE)-1:0]   o_res_col,
  output logic                                o_res_last,
  output logic                                o_ovf,
  output logic                                o_done
);

  localparam int unsigned NUM_BLK = num_blk(MATRIX_SIZE, BLOCK_SIZE);
  localparam int unsigned BLK_W   = idx_width(NUM_BLK);
  localparam int unsigned CW      = idx_width(MATRIX_SIZE);

  typedef struct packed {
    logic [ACC_WIDTH-1:0] data;
    logic [CW-1:0]        row;
    logic [CW-1:0]        col;
    logic                 last;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  // Elaboration-time parameter checks.
  if (BLOCK_SIZE == 0) begin : g_err_blk_zero
    $error("block_accum: BLOCK_SIZE must be nonzero");
  end else if ((MATRIX_SIZE % BLOCK_SIZE) != 0) begin : g_err_blk_div
    $error("block_accum: MATRIX_SIZE must be a multiple of BLOCK_SIZE");
  end
  if (ACC_WIDTH < PART_WIDTH) begin : g_err_acc_w
    $error("block_accum: ACC_WIDTH must be >= PART_WIDTH");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_err_depth
    $error("block_accum: FIFO_DEPTH must be a power of two >= 2");
  end

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BLK_W-1:0]     r_blk;
  logic [CW-1:0]        r_col;
  logic [CW-1:0]        r_row;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_ovf;
  logic                 r_part_ready;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_blk_last;
  logic                 w_col_last;
  logic                 w_row_last;
  logic                 w_mat_last;
  logic [ACC_WIDTH-1:0] w_base;
  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_sat;
  logic                 w_push;
  logic                 w_part_ready_nxt;
  logic                 w_done_nxt;

  logic                 w_fifo_valid;
  logic                 w_fifo_full;
  logic                 w_fifo_full_nxt;
  logic                 w_fifo_empty_nxt;
  logic [ENTRY_W-1:0]   w_fifo_dout;
  entry_t               w_push_entry;
  entry_t               w_head;

  assign w_accept   = i_part_valid & r_part_ready;
  assign w_blk_last = (r_blk == BLK_W'(NUM_BLK - 1));
  assign w_col_last = (r_col == CW'(MATRIX_SIZE - 1));
  assign w_row_last = (r_row == CW'(MATRIX_SIZE - 1));
  assign w_mat_last = w_blk_last & w_col_last & w_row_last;
  assign w_push     = w_accept & w_blk_last;

  // First partial of an element starts from zero instead of the stale sum.
  assign w_base = (r_blk == '0) ? '0 : r_acc;

`ifdef BLOCK_ACCUM_SAT_EN
  logic [ACC_WIDTH:0] w_sum_wide;
  assign w_sum_wide = {1'b0, w_base} + (ACC_WIDTH + 1)'(i_part_data);
  assign w_sat      = w_sum_wide[ACC_WIDTH];
  assign w_sum      = w_sat ? '1 : w_sum_wide[ACC_WIDTH-1:0];
`else
  assign w_sat = 1'b0;
  assign w_sum = w_base + ACC_WIDTH'(i_part_data);
`endif

  // FSM state register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state: DRAIN waits for the registered FIFO to show empty.
  always_comb begin
    w_state_nxt = r_state;
    if (i_clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACCUM: begin
          if (w_accept) w_state_nxt = w_mat_last ? ST_DRAIN : ST_ACCUM;
        end
        ST_DRAIN: begin
          if (!w_fifo_valid) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM outputs, computed from next-cycle state so they can be registered.
  // done fires in the first DRAIN cycle with an empty FIFO; ready is still
  // low then, so a new matrix starts no earlier than the cycle after.
  always_comb begin
    w_part_ready_nxt = (w_state_nxt != ST_DRAIN) & ~w_fifo_full_nxt;
    w_done_nxt       = ~i_clear & (w_state_nxt == ST_DRAIN) & w_fifo_empty_nxt;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_part_ready <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_part_ready <= w_part_ready_nxt;
      r_done       <= w_done_nxt;
    end
  end

  // Element counters and running sum; the completing sum goes straight to
  // the FIFO, so the accumulator is only written for non-final partials.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_blk <= '0;
      r_col <= '0;
      r_row <= '0;
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_clear) begin
      r_blk <= '0;
      r_col <= '0;
      r_row <= '0;
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= r_ovf | w_sat;
      if (w_blk_last) begin
        r_blk <= '0;
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + CW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end else begin
        r_blk <= r_blk + BLK_W'(1);
        r_acc <= w_sum;
      end
    end
  end

  assign w_push_entry = '{data: w_sum, row: r_row, col: r_col, last: w_mat_last};

  res_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_clear       (i_clear),
    .i_push        (w_push),
    .i_data        (w_push_entry),
    .i_pop         (i_res_ready),
    .o_data        (w_fifo_dout),
    .o_valid       (w_fifo_valid),
    .o_full        (w_fifo_full),
    .o_full_nxt_c  (w_fifo_full_nxt),
    .o_empty_nxt_c (w_fifo_empty_nxt)
  );

  assign w_head = w_fifo_dout;

  // All outputs come straight from flops (FSM regs or the FIFO head).
  assign o_part_ready = r_part_ready & ~(w_fifo_full & 1'b0);
  assign o_res_valid  = w_fifo_valid;
  assign o_res_data   = w_head.data;
  assign o_res_row    = w_head.row;
  assign o_res_col    = w_head.col;
  assign o_res_last   = w_head.last;
  assign o_ovf        = r_ovf;
  assign o_done       = r_done;

endmodule

// File: tb/tb_block_accum.sv
// Directed bench for block_accum: default 3x3 build, a 6x6 build with two
// partials per element, and a 4-bit build exercising saturation/wrap.
module tb_block_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Default configuration (N=3, one partial per element)
  logic        c0_clear = 0, c0_pv = 0, c0_rr = 0;
  logic [17:0] c0_pd = '0;
  logic        c0_prdy, c0_rv, c0_last, c0_ovf, c0_done;
  logic [19:0] c0_rd;
  logic [1:0]  c0_row, c0_col;

  // N=6, BLOCK=3 (two partials per element)
  logic        c6_clear = 0, c6_pv = 0, c6_rr = 0;
  logic [17:0] c6_pd = '0;
  logic        c6_prdy, c6_rv, c6_last, c6_ovf, c6_done;
  logic [19:0] c6_rd;
  logic [2:0]  c6_row, c6_col;

  // 4-bit accumulator, N=2, BLOCK=1 (two partials per element)
  logic        cs_clear = 0, cs_pv = 0, cs_rr = 0;
  logic [3:0]  cs_pd = '0;
  logic        cs_prdy, cs_rv, cs_last, cs_ovf, cs_done;
  logic [3:0]  cs_rd;
  logic [0:0]  cs_row, cs_col;

  block_accum u_dut0 (
    .i_clock(clk), .i_reset(rst), .i_clear(c0_clear),
    .i_part_valid(c0_pv), .o_part_ready(c0_prdy), .i_part_data(c0_pd),
    .o_res_valid(c0_rv), .i_res_ready(c0_rr), .o_res_data(c0_rd),
    .o_res_row(c0_row), .o_res_col(c0_col), .o_res_last(c0_last),
    .o_ovf(c0_ovf), .o_done(c0_done)
  );

  block_accum #(.MATRIX_SIZE(6), .BLOCK_SIZE(3)) u_dut6 (
    .i_clock(clk), .i_reset(rst), .i_clear(c6_clear),
    .i_part_valid(c6_pv), .o_part_ready(c6_prdy), .i_part_data(c6_pd),
    .o_res_valid(c6_rv), .i_res_ready(c6_rr), .o_res_data(c6_rd),
    .o_res_row(c6_row), .o_res_col(c6_col), .o_res_last(c6_last),
    .o_ovf(c6_ovf), .o_done(c6_done)
  );

  block_accum #(.MATRIX_SIZE(2), .BLOCK_SIZE(1), .PART_WIDTH(4), .ACC_WIDTH(4)) u_dut_sat (
    .i_clock(clk), .i_reset(rst), .i_clear(cs_clear),
    .i_part_valid(cs_pv), .o_part_ready(cs_prdy), .i_part_data(cs_pd),
    .o_res_valid(cs_rv), .i_res_ready(cs_rr), .o_res_data(cs_rd),
    .o_res_row(cs_row), .o_res_col(cs_col), .o_res_last(cs_last),
    .o_ovf(cs_ovf), .o_done(cs_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Partials 1..9 back-to-back with res_ready high; expects state IDLE, ready 1.
  task automatic run_basic(input string pfx);
    c0_rr = 1'b1;
    chk({pfx, "_ready_start"}, 64'(c0_prdy), 64'd1);
    for (int k = 1; k <= 9; k++) begin
      c0_pv = 1'b1;
      c0_pd = 18'(k);
      step();
      chk($sformatf("%s_valid[%0d]", pfx, k), 64'(c0_rv), 64'd1);
      chk($sformatf("%s_data[%0d]", pfx, k), 64'(c0_rd), 64'(k));
      chk($sformatf("%s_row[%0d]", pfx, k), 64'(c0_row), 64'((k - 1) / 3));
      chk($sformatf("%s_col[%0d]", pfx, k), 64'(c0_col), 64'((k - 1) % 3));
      chk($sformatf("%s_last[%0d]", pfx, k), 64'(c0_last), 64'(k == 9));
      chk($sformatf("%s_ready[%0d]", pfx, k), 64'(c0_prdy), 64'(k != 9));
      chk($sformatf("%s_done[%0d]", pfx, k), 64'(c0_done), 64'd0);
    end
    c0_pv = 1'b0;
    step();
    chk({pfx, "_done_pulse"}, 64'(c0_done), 64'd1);
    chk({pfx, "_drained_valid"}, 64'(c0_rv), 64'd0);
    chk({pfx, "_drained_hold"}, 64'(c0_rd), 64'd9);
    chk({pfx, "_drain_ready"}, 64'(c0_prdy), 64'd0);
    step();
    chk({pfx, "_done_single"}, 64'(c0_done), 64'd0);
    chk({pfx, "_ready_again"}, 64'(c0_prdy), 64'd1);
  endtask

  initial begin
    int acc_n, got, done_n, a, b;
    logic take;
    int exp_sat_data, exp_ovf;

    // Reset state
    step();
    chk("rst_ready", 64'(c0_prdy), 64'd0);
    chk("rst_valid", 64'(c0_rv), 64'd0);
    chk("rst_data", 64'(c0_rd), 64'd0);
    chk("rst_row", 64'(c0_row), 64'd0);
    chk("rst_col", 64'(c0_col), 64'd0);
    chk("rst_last", 64'(c0_last), 64'd0);
    chk("rst_ovf", 64'(c0_ovf), 64'd0);
    chk("rst_done", 64'(c0_done), 64'd0);
    chk("rst_valid6", 64'(c6_rv), 64'd0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", 64'(c0_prdy), 64'd1);

    // Default build streaming run
    run_basic("basic");

    // N=6, two partials per element
    c6_rr = 1'b1;
    for (int e = 0; e < 36; e++) begin
      a = (e == 1) ? 7 : 10 + 3 * e;
      b = (e % 2 == 0) ? 5 : 0;
      c6_pv = 1'b1;
      c6_pd = 18'(a);
      step();
      chk($sformatf("m6_mid_valid[%0d]", e), 64'(c6_rv), 64'd0);
      c6_pd = 18'(b);
      step();
      chk($sformatf("m6_valid[%0d]", e), 64'(c6_rv), 64'd1);
      chk($sformatf("m6_data[%0d]", e), 64'(c6_rd), 64'(a + b));
      chk($sformatf("m6_row[%0d]", e), 64'(c6_row), 64'(e / 6));
      chk($sformatf("m6_col[%0d]", e), 64'(c6_col), 64'(e % 6));
      chk($sformatf("m6_last[%0d]", e), 64'(c6_last), 64'(e == 35));
    end
    c6_pv = 1'b0;
    step();
    chk("m6_done", 64'(c6_done), 64'd1);

    // Backpressure: res_ready low, only FIFO_DEPTH partials fit
    c0_rr = 1'b0;
    acc_n = 0;
    for (int c = 0; c < 8; c++) begin
      c0_pv = 1'b1;
      c0_pd = 18'(acc_n + 1);
      take = c0_prdy;
      step();
      if (take) acc_n++;
    end
    chk("bp_accepted", 64'(acc_n), 64'd4);
    chk("bp_ready_low", 64'(c0_prdy), 64'd0);
    chk("bp_head_valid", 64'(c0_rv), 64'd1);
    chk("bp_head_data", 64'(c0_rd), 64'd1);
    c0_rr = 1'b1;
    got = 0;
    done_n = 0;
    for (int c = 0; c < 30; c++) begin
      c0_pv = (acc_n < 9);
      c0_pd = 18'(acc_n + 1);
      take = c0_prdy & c0_pv;
      if (c0_done) done_n++;
      if (c0_rv) begin
        chk($sformatf("bp_out_data[%0d]", got), 64'(c0_rd), 64'(got + 1));
        chk($sformatf("bp_out_row[%0d]", got), 64'(c0_row), 64'(got / 3));
        chk($sformatf("bp_out_col[%0d]", got), 64'(c0_col), 64'(got % 3));
        got++;
      end
      step();
      if (take) acc_n++;
    end
    chk("bp_total_in", 64'(acc_n), 64'd9);
    chk("bp_total_out", 64'(got), 64'd9);
    chk("bp_done_count", 64'(done_n), 64'd1);
    chk("bp_ready_end", 64'(c0_prdy), 64'd1);

    // Clear after 5 of 9 elements
    c0_rr = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      c0_pv = 1'b1;
      c0_pd = 18'(k);
      step();
    end
    chk("clr_pre_valid", 64'(c0_rv), 64'd1);
    chk("clr_pre_data", 64'(c0_rd), 64'd5);
    c0_pv = 1'b0;
    c0_clear = 1'b1;
    step();
    c0_clear = 1'b0;
    chk("clr_valid", 64'(c0_rv), 64'd0);
    chk("clr_data", 64'(c0_rd), 64'd0);
    chk("clr_ready", 64'(c0_prdy), 64'd1);
    chk("clr_done", 64'(c0_done), 64'd0);
    c0_pv = 1'b1;
    c0_pd = 18'd42;
    step();
    chk("clr_next_valid", 64'(c0_rv), 64'd1);
    chk("clr_next_data", 64'(c0_rd), 64'd42);
    chk("clr_next_row", 64'(c0_row), 64'd0);
    chk("clr_next_col", 64'(c0_col), 64'd0);
    chk("clr_next_done", 64'(c0_done), 64'd0);

    // Reset mid-accumulation with results waiting
    c0_rr = 1'b0;
    c0_pd = 18'd43;
    step();
    c0_pd = 18'd44;
    step();
    c0_pv = 1'b0;
    chk("mid_pre_valid", 64'(c0_rv), 64'd1);
    chk("mid_pre_data", 64'(c0_rd), 64'd42);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(c0_rv), 64'd0);
    chk("arst_data", 64'(c0_rd), 64'd0);
    chk("arst_row", 64'(c0_row), 64'd0);
    chk("arst_col", 64'(c0_col), 64'd0);
    chk("arst_ready", 64'(c0_prdy), 64'd0);
    chk("arst_done", 64'(c0_done), 64'd0);
    step();
    rst = 1'b0;
    step();
    run_basic("rerun");

    // Saturation / wrap on the 4-bit build: 12 + 9
`ifdef BLOCK_ACCUM_SAT_EN
    exp_sat_data = 15;
    exp_ovf = 1;
`else
    exp_sat_data = 5;
    exp_ovf = 0;
`endif
    cs_rr = 1'b1;
    cs_pv = 1'b1;
    cs_pd = 4'd12;
    step();
    cs_pd = 4'd9;
    step();
    chk("sat_valid", 64'(cs_rv), 64'd1);
    chk("sat_data", 64'(cs_rd), 64'(exp_sat_data));
    chk("sat_ovf", 64'(cs_ovf), 64'(exp_ovf));
    cs_pd = 4'd1;
    step();
    cs_pd = 4'd2;
    step();
    cs_pv = 1'b0;
    chk("sat_small_data", 64'(cs_rd), 64'd3);
    chk("sat_small_col", 64'(cs_col), 64'd1);
    chk("sat_ovf_sticky", 64'(cs_ovf), 64'(exp_ovf));
    cs_clear = 1'b1;
    step();
    cs_clear = 1'b0;
    chk("sat_ovf_cleared", 64'(cs_ovf), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/block_accum.md
# block_accum

Downstream stage of the block dot-product unit in the blocked matrix-multiply datapath. Consumes per-block partial dot products, one per handshake, sums the MATRIX_SIZE/BLOCK_SIZE partials belonging to each result element, and buffers finished elements in a small FIFO. Finished elements stream out in row-major order with row/column tags and a last-element marker.

## Interface
- DATA_WIDTH, 8: operand element width; sets PART_WIDTH and ACC_WIDTH defaults
- MATRIX_SIZE, 3: square matrix dimension N
- BLOCK_SIZE, 3: dot-product block length; MATRIX_SIZE % BLOCK_SIZE == 0 required, elaboration error otherwise
- PART_WIDTH, 2*DATA_WIDTH+2: width of incoming partial
- ACC_WIDTH, 2*DATA_WIDTH+4: accumulator and result width, ≥ PART_WIDTH
- FIFO_DEPTH, 4: result FIFO entries, power of two, ≥ 2
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- clear  in  1  synchronous abort: drop partial sum, counters, FIFO
- part_valid  in  1  partial present
- part_ready  out  1  partial accepted when valid & ready
- part_data  in  PART_WIDTH  unsigned partial dot product
- res_valid  out  1  FIFO head valid
- res_ready  in  1  consumer accepts head
- res_data  out  ACC_WIDTH  accumulated element
- res_row, res_col  out  $clog2(MATRIX_SIZE) (min 1)  element coordinates
- res_last  out  1  head is element (N-1,N-1)
- ovf  out  1  sticky saturation flag
- done  out  1  one-cycle pulse after last element of matrix drains

## Operation
- NUM_BLK = MATRIX_SIZE/BLOCK_SIZE. Partials arrive element-major (row, col row-major), NUM_BLK consecutive partials per element.
- Counters blk_cnt (0..NUM_BLK-1), col_cnt, row_cnt (0..N-1); advance only on accepted partial; blk wraps → col++; col wraps → row++.
- Accept with blk_cnt==0: acc ← part_data (zero-extended). Otherwise acc ← acc + part_data.
- Accept with blk_cnt==NUM_BLK-1: push {acc+part (or part if NUM_BLK==1), row, col, last} to FIFO; acc not separately registered in that case.
- States: IDLE → ACCUM on first accepted partial; ACCUM → DRAIN on accepting last partial of (N-1,N-1); DRAIN → IDLE when FIFO empty, asserting done for that cycle.
- part_ready = (state != DRAIN) & !fifo_full. Depends on registered state only; no path from res_ready.
- Unsigned arithmetic throughout.
- clear: next edge returns to IDLE, counters/acc/FIFO zero, ovf cleared, done not pulsed; clear overrides simultaneous push/pop.

## Timing
- Reset values: part_ready 0 during reset, 1 from first edge after release; res_valid 0, res_data 0, res_row 0, res_col 0, res_last 0, ovf 0, done 0; state IDLE; FIFO empty.
- Latency: last partial accepted at edge t → res_valid high after t (visible cycle t+1) when FIFO empty. Show-ahead FIFO, registered outputs.
- Full FIFO with simultaneous pop: part_ready still 0 that cycle (one-cycle bubble accepted).
- Empty FIFO: res_valid 0, res_data holds last value.
- res_valid/res_data stable while res_valid & !res_ready.
- done: single cycle, the cycle the FIFO becomes empty in DRAIN; next partial accepted no earlier than following cycle.
- Reset mid-operation: all state lost immediately, outputs to reset values asynchronously.

## Configuration
- BLOCK_ACCUM_SAT_EN defined: sum exceeding 2^ACC_WIDTH-1 clamps to all-ones, ovf set sticky until clear/reset.
- Undefined: sum wraps modulo 2^ACC_WIDTH; ovf tied 0.

## Structure
- Shared package blk_mm_pkg: default width constants, NUM_BLK function, state enum (IDLE, ACCUM, DRAIN), FIFO entry struct {data, row, col, last}.
- One sub-module: res_fifo (synchronous show-ahead FIFO, parameterised width/depth, full/empty).

## Test plan
- Default params (NUM_BLK=1): partials 1..9 back-to-back, res_ready=1 → outputs 1..9, tags (0,0)..(2,2), res_last on 9, done one cycle after drain.
- MATRIX_SIZE=6, BLOCK_SIZE=3: partial pairs (10,5),(7,0)… → res_data 15, 7…; 36 elements, tags row-major.
- res_ready=0 throughout: exactly 4 results accepted, part_ready drops; release res_ready → results in order, no loss/duplication.
- SAT_EN, ACC_WIDTH=4, PART_WIDTH=4, NUM_BLK=2: partials 12,9 → res_data 15, ovf 1; without macro → 5, ovf 0.
- clear asserted after 5 of 9 elements → FIFO empty, res_valid 0, next partial tagged (0,0), no done.
- reset asserted mid-accumulation with res_valid high → all outputs 0 asynchronously; normal run afterwards matches scenario 1.
